// File: rtl/dispatch1to4.sv
// dispatch1to4: registered 1-to-4 dispatcher.
// One valid/ready input stream with a 2-bit destination select feeds four
// independent one-entry output registers, each with its own valid/ready
// handshake. A full port only blocks words aimed at itself.
// Optional build macro: DISPATCH1TO4_STATS_EN adds saturating per-port
// delivery counters (cnt0..cnt3) and an input stall counter (stall_cnt).
module dispatch1to4 #(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] out0_data,
  output logic [DATA_SIZE-1:0] out1_data,
  output logic [DATA_SIZE-1:0] out2_data,
  output logic [DATA_SIZE-1:0] out3_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
`ifdef DISPATCH1TO4_STATS_EN
  ,
  output logic [15:0]          cnt0,
  output logic [15:0]          cnt1,
  output logic [15:0]          cnt2,
  output logic [15:0]          cnt3,
  output logic [15:0]          stall_cnt
`endif
);

  logic [3:0]           vld_q, vld_d;
  logic [DATA_SIZE-1:0] dat_q [4];
  logic [DATA_SIZE-1:0] dat_d [4];
  logic [3:0]           drain;
  logic [3:0]           load;
  logic                 accept;

  // Selected port can take a word if empty or being drained this cycle.
  assign in_ready = ~vld_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign drain    = vld_q & out_ready;

  // Decode the accepted word onto exactly one port.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      load[k] = accept & (in_sel == 2'(k));
    end
  end

  // Per-port next state: load beats drain, so drain+load keeps the port full.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < 4; k++) begin
      dat_d[k] = dat_q[k];
      if (load[k]) begin
        vld_d[k] = 1'b1;
        dat_d[k] = in_data;
      end else if (drain[k]) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < 4; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign out_valid = vld_q;
  assign out0_data = dat_q[0];
  assign out1_data = dat_q[1];
  assign out2_data = dat_q[2];
  assign out3_data = dat_q[3];

`ifdef DISPATCH1TO4_STATS_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [15:0] stall_q, stall_d;

  // Saturating counters: deliveries per port and cycles the producer waited.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (drain[k] && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Counter registers, cleared with the datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      stall_q <= stall_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dispatch1to4.sv
// Bench for dispatch1to4: directed steps followed by random traffic, all
// checked against a port-occupancy model kept in this file.
module tb_dispatch1to4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data, out3_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DISPATCH1TO4_STATS_EN
  logic [15:0] cnt0, cnt1, cnt2, cnt3, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dispatch1to4 #(.DATA_SIZE(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DISPATCH1TO4_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .stall_cnt (stall_cnt)
`endif
  );

  logic [31:0] od [4];
  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign od[3] = out3_data;

  // Reference model: each port is a one-word mailbox.
  bit          m_full [4];
  logic [31:0] m_dat  [4];
  int          m_cnt  [4];
  int          m_stall;

  function automatic bit exp_ready();
    return !m_full[in_sel] || out_ready[in_sel];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_dat[k]  = '0;
      m_cnt[k]  = 0;
    end
    m_stall = 0;
  endtask

  task automatic check_outputs();
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = m_full[k];
    chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out%0d_data", k), od[k], m_dat[k]);
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
`ifdef DISPATCH1TO4_STATS_EN
    chk("cnt0", {16'd0, cnt0}, m_cnt[0]);
    chk("cnt1", {16'd0, cnt1}, m_cnt[1]);
    chk("cnt2", {16'd0, cnt2}, m_cnt[2]);
    chk("cnt3", {16'd0, cnt3}, m_cnt[3]);
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
  endtask

  // One clock: check at the falling edge, advance the model, step past the edge.
  task automatic cycle();
    bit rdy;
    @(negedge clk);
    check_outputs();
    if (!reset) begin
      model_clear();
    end else begin
      rdy = exp_ready();
      if (in_valid && !rdy && m_stall < 65535) m_stall++;
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && out_ready[k]) begin
          m_full[k] = 1'b0;
          if (m_cnt[k] < 65535) m_cnt[k]++;
        end
      end
      if (in_valid && rdy) begin
        m_full[in_sel] = 1'b1;
        m_dat[in_sel]  = in_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    // Reset held two cycles with a valid word present.
    reset = 1'b0;
    drive(1'b1, 2'd1, 32'h1234_5678, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    reset = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    @(negedge clk);
    check_outputs();
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Single dispatch to port 2, held until its consumer is ready.
    drive(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    repeat (3) cycle();
    chk("single_hold", out2_data, 32'hDEAD_BEEF);
    out_ready = 4'b0100;
    cycle();
    out_ready = 4'b0000;
    cycle();
    chk("single_drained", {28'd0, out_valid}, 32'd0);

    // Backpressure isolation: full port 1 blocks only itself.
    drive(1'b1, 2'd1, 32'h0000_0011, 4'b0000);
    cycle();
    drive(1'b1, 2'd1, 32'h0000_0022, 4'b0000);
    #1;
    chk("bp_blocked", {31'd0, in_ready}, 32'd0);
    in_sel  = 2'd3;
    in_data = 32'h0000_0033;
    #1;
    chk("bp_other", {31'd0, in_ready}, 32'd1);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    cycle();
    chk("bp_port3", out3_data, 32'h0000_0033);
    chk("bp_port1", out1_data, 32'h0000_0011);
    out_ready = 4'b1111;
    cycle();

    // Streaming back-to-back with all consumers ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'((i - 1) % 4), 32'(i), 4'b1111);
      cycle();
    end
    drive(1'b0, 2'd0, 32'h0, 4'b1111);
    cycle();

    // Same-port drain and load in one cycle.
    drive(1'b1, 2'd0, 32'hA, 4'b0000);
    cycle();
    drive(1'b1, 2'd0, 32'hB, 4'b0001);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    cycle();
    chk("dl_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("dl_data", out0_data, 32'hB);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      cycle();
    end
    reset = 1'b1;

`ifdef DISPATCH1TO4_STATS_EN
    // Three stall cycles then five deliveries on port 2.
    reset = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    cycle();
    reset = 1'b1;
    drive(1'b1, 2'd2, 32'h100, 4'b0000);
    cycle();
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd2, 32'h200 + 32'(i), 4'b0100);
      cycle();
    end
    drive(1'b0, 2'd0, 32'h0, 4'b0100);
    cycle();
    chk("stats_stall", {16'd0, stall_cnt}, 32'd3);
    chk("stats_cnt2", {16'd0, cnt2}, 32'd5);
    chk("stats_cnt0", {16'd0, cnt0}, 32'd0);

    // Saturation of a delivery counter.
    drive(1'b1, 2'd0, 32'h5, 4'b0001);
    repeat (70000) cycle();
    chk("stats_sat", {16'd0, cnt0}, 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
